pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage pipeline: drives the enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Detects RAW hazards between ID-stage source registers and in-flight destinations, and stalls with bubble insertion. The pipeline has no forwarding.
- Provides run / single-step / halt-with-drain control for the host interface.
- Sits beside the stage registers. `id_ex_bubble` gates `w_reg_en`/`w_mem_en` to 0 at the ID/EX register input.

Parameters:
- REG_ADDR_WIDTH, 3, register address width.
- STALL_CNT_WIDTH, 8, width of the saturating stall counter.
- DRAIN_CYCLES, 3, bubble cycles issued in DRAIN (flushes EX, MEM, WB); must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; run pipeline while high.
- step_req  in  1  single-cycle pulse; advance one cycle from IDLE.
- halt_req  in  1  single-cycle pulse; stop and drain.
- id_rs1, id_rs2  in  REG_ADDR_WIDTH each  ID-stage source register addresses.
- id_rs1_vld, id_rs2_vld  in  1 each  the source is actually read.
- ex_wreg, mem_wreg, wb_wreg  in  REG_ADDR_WIDTH each  destinations in EX, MEM, WB.
- ex_wreg_en, mem_wreg_en, wb_wreg_en  in  1 each  the corresponding write enables.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register enables.
- id_ex_bubble  out  1  force a NOP into ID/EX.
- hazard  out  1  RAW hazard detected this cycle (combinational).
- busy  out  1  state != IDLE.
- state  out  2  IDLE=0, RUN=1, STEP=2, DRAIN=3.
- stall_count  out  STALL_CNT_WIDTH  total hazard-stall cycles.

Behaviour:
- Clock and reset: single clock `clk`. `reset` is asynchronous and active-high.
- Reset values: state=IDLE, stall_count=0, drain counter=0. All enables, id_ex_bubble and busy are 0.
- Registered state: state, drain counter, stall_count.
- Combinational outputs: enables, bubble and hazard are decoded from the registered state plus the current inputs.
- Hazard term: for each source s with vld=1, the source matches any stage X in {ex, mem, wb} where X_wreg_en=1 and X_wreg==s. The register file writes at the end of WB with no write-through, so a WB match is a hazard.
- Output decode per state:
  - IDLE: all enables 0, bubble 0.
  - RUN or STEP, no hazard: all five enables 1, bubble 0.
  - RUN or STEP, hazard: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1, mem_wb_en=1. The ID instruction is held; older instructions advance.
  - DRAIN: pc_en=0, if_id_en=0, id_ex_bubble=1, other enables 1. The held IF/ID instruction survives, so a restart resumes correctly.
- FSM transitions (priority halt_req > step_req > run):
  - IDLE: step_req → STEP; else run=1 → RUN. A halt_req in IDLE is ignored.
  - RUN: halt_req or run=0 → DRAIN, loading the drain counter with DRAIN_CYCLES-1.
  - STEP: exactly one cycle, → IDLE. A step taken during a hazard issues a bubble only. halt_req in STEP → IDLE, since nothing extra is in flight.
  - DRAIN: decrement the counter; at 0 → IDLE. run, step_req and halt_req are ignored until IDLE. With run held high, IDLE lasts exactly 1 cycle before RUN.
- stall_count: +1 on each cycle with state ∈ {RUN, STEP} and hazard=1. Saturates at all-ones and does not wrap. Cleared only by reset.
- Reset mid-operation: an immediate async return to IDLE, with all enables dropping to 0 in the same cycle. The stage registers are reset by the same signal.

Optional Feature:
- Macro: PIPE_HAZARD_ZERO_REG_EN.
- Defined: register address 0 is hardwired zero; a source or destination of 0 never produces a hazard.
- Undefined: all addresses, including 0, participate in hazard comparison.

Decomposition:
- Shared package `pipe_ctrl_pkg` holds:
  - the state encoding constants (IDLE, RUN, STEP, DRAIN);
  - REG_ADDR_WIDTH default;
  - the stage enable bundle ordering.
- One natural sub-module, `raw_hazard_detect`: purely combinational, 2 sources × 3 destinations compare, honours PIPE_HAZARD_ZERO_REG_EN.
- The FSM and counters stay in the top module.

Test Plan:
- Reset → all enables 0, state=0, stall_count=0. Assert reset mid-RUN → enables fall to 0 within the same cycle.
- run=1, id_rs1=2 vld, ex_wreg=2 en → 3 consecutive hazard cycles (EX→MEM→WB) with pc_en=0, id_ex_bubble=1, then no hazard; stall_count=3.
- IDLE, step_req pulse → exactly 1 cycle with all enables 1, state returns to 0. step_req during hazard → 1 bubble cycle, pc_en=0.
- RUN, halt_req pulse → DRAIN for 3 cycles (pc_en=0, bubble=1, ex_mem_en=1), then IDLE; run held 1 → RUN after exactly 1 IDLE cycle.
- id_rs2=0 vld, wb_wreg=0 en → hazard=1 without the macro, hazard=0 with PIPE_HAZARD_ZERO_REG_EN.
- STALL_CNT_WIDTH=2, 5 hazard cycles → stall_count saturates at 3.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state encoding,
// default register-address width and the stage-enable bundle ordering.
package pipe_ctrl_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Stage enables ordered from the front of the pipe (PC) to the back (MEM/WB).
  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_en_t;

  localparam stage_en_t EN_NONE = '0;
  localparam stage_en_t EN_ALL  = '1;
  // Front of the pipe frozen, older instructions keep moving.
  localparam stage_en_t EN_HOLD_FRONT = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b1,
                                         ex_mem: 1'b1, mem_wb: 1'b1};

endpackage

// File: rtl/raw_hazard_detect.sv
// Combinational RAW hazard compare: two ID-stage sources against the EX, MEM
// and WB destinations. No forwarding exists and the register file has no
// write-through, so a WB match is still a hazard.
// Build option: define PIPE_HAZARD_ZERO_REG_EN to treat register 0 as
// hardwired zero (never a hazard source or destination).
module raw_hazard_detect #(
  parameter int ADDR_WIDTH = pipe_ctrl_pkg::DEF_REG_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  input  logic                  rs1_vld,
  input  logic                  rs2_vld,
  input  logic [ADDR_WIDTH-1:0] ex_wreg,
  input  logic [ADDR_WIDTH-1:0] mem_wreg,
  input  logic [ADDR_WIDTH-1:0] wb_wreg,
  input  logic                  ex_wreg_en,
  input  logic                  mem_wreg_en,
  input  logic                  wb_wreg_en,
  output logic                  hazard
);

  function automatic logic dst_hit(input logic [ADDR_WIDTH-1:0] src,
                                   input logic [ADDR_WIDTH-1:0] dst,
                                   input logic                  dst_en);
`ifdef PIPE_HAZARD_ZERO_REG_EN
    // Equality plus a non-zero source also rules out a zero destination.
    return dst_en && (dst == src) && (src != '0);
`else
    return dst_en && (dst == src);
`endif
  endfunction

  function automatic logic src_hit(input logic [ADDR_WIDTH-1:0] src,
                                   input logic                  src_vld);
    return src_vld && (dst_hit(src, ex_wreg,  ex_wreg_en)  ||
                       dst_hit(src, mem_wreg, mem_wreg_en) ||
                       dst_hit(src, wb_wreg,  wb_wreg_en));
  endfunction

  assign hazard = src_hit(rs1, rs1_vld) || src_hit(rs2, rs2_vld);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the 5-stage pipeline: stage-register enables,
// RAW stall with bubble insertion, and run / single-step / halt-with-drain
// control. Build option PIPE_HAZARD_ZERO_REG_EN is honoured by the hazard
// detector.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH  = pipe_ctrl_pkg::DEF_REG_ADDR_WIDTH,
  parameter int STALL_CNT_WIDTH = 8,
  parameter int DRAIN_CYCLES    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       step_req,
  input  logic                       halt_req,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs2,
  input  logic                       id_rs1_vld,
  input  logic                       id_rs2_vld,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_wreg,
  input  logic [REG_ADDR_WIDTH-1:0]  mem_wreg,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_wreg,
  input  logic                       ex_wreg_en,
  input  logic                       mem_wreg_en,
  input  logic                       wb_wreg_en,
  output logic                       pc_en,
  output logic                       if_id_en,
  output logic                       id_ex_en,
  output logic                       ex_mem_en,
  output logic                       mem_wb_en,
  output logic                       id_ex_bubble,
  output logic                       hazard,
  output logic                       busy,
  output logic [1:0]                 state,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);
  import pipe_ctrl_pkg::*;

  localparam int DRAIN_CNT_WIDTH = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_LOAD = DRAIN_CNT_WIDTH'(DRAIN_CYCLES - 1);
  localparam logic [DRAIN_CNT_WIDTH-1:0] DRAIN_ONE  = DRAIN_CNT_WIDTH'(1);
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE  = STALL_CNT_WIDTH'(1);

  state_e                     state_q, state_d;
  logic [DRAIN_CNT_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
  stage_en_t                  stage_en;
  logic                       bubble;
  logic                       raw_hazard;
  logic                       issuing;

  raw_hazard_detect #(
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_detect (
    .rs1         (id_rs1),
    .rs2         (id_rs2),
    .rs1_vld     (id_rs1_vld),
    .rs2_vld     (id_rs2_vld),
    .ex_wreg     (ex_wreg),
    .mem_wreg    (mem_wreg),
    .wb_wreg     (wb_wreg),
    .ex_wreg_en  (ex_wreg_en),
    .mem_wreg_en (mem_wreg_en),
    .wb_wreg_en  (wb_wreg_en),
    .hazard      (raw_hazard)
  );

  // RUN and STEP are the states that issue instructions from ID.
  assign issuing = (state_q == ST_RUN) || (state_q == ST_STEP);

  // State and drain-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state, drain-counter update and stage-enable decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stage_en    = EN_NONE;
    bubble      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // halt_req has nothing to stop here and is ignored.
        if (step_req) begin
          state_d = ST_STEP;
        end else if (run) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (raw_hazard) begin
          stage_en = EN_HOLD_FRONT;
          bubble   = 1'b1;
        end else begin
          stage_en = EN_ALL;
        end
        if (halt_req || !run) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      ST_STEP: begin
        // One issue slot only; a hazard turns it into a single bubble.
        if (raw_hazard) begin
          stage_en = EN_HOLD_FRONT;
          bubble   = 1'b1;
        end else begin
          stage_en = EN_ALL;
        end
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // Flush EX/MEM/WB while the held IF/ID instruction stays put.
        stage_en = EN_HOLD_FRONT;
        bubble   = 1'b1;
        if (drain_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_ONE;
        end
      end
    endcase
  end

  // Saturating count of issue cycles lost to RAW stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (issuing && raw_hazard && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + STALL_ONE;
    end
  end

  assign pc_en        = stage_en.pc;
  assign if_id_en     = stage_en.if_id;
  assign id_ex_en     = stage_en.id_ex;
  assign ex_mem_en    = stage_en.ex_mem;
  assign mem_wb_en    = stage_en.mem_wb;
  assign id_ex_bubble = bubble;
  assign hazard       = raw_hazard;
  assign busy         = (state_q != ST_IDLE);
  assign state        = state_q;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations followed by randomized stimulus compared every cycle against a
// behavioural model. A second instance with a 2-bit stall counter exercises
// saturation.
module tb_pipe_hazard_ctrl;

  localparam int AW    = 3;
  localparam int DRAIN = 3;

`ifdef PIPE_HAZARD_ZERO_REG_EN
  localparam logic ZERO_HZ_EXP = 1'b0;
`else
  localparam logic ZERO_HZ_EXP = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0, step_req = 1'b0, halt_req = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0;
  logic          id_rs1_vld = 1'b0, id_rs2_vld = 1'b0;
  logic [AW-1:0] ex_wreg = '0, mem_wreg = '0, wb_wreg = '0;
  logic          ex_wreg_en = 1'b0, mem_wreg_en = 1'b0, wb_wreg_en = 1'b0;

  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       id_ex_bubble, hazard, busy;
  logic [1:0] dut_state;
  logic [7:0] stall_count;

  logic       n_pc_en, n_if_id_en, n_id_ex_en, n_ex_mem_en, n_mem_wb_en;
  logic       n_bubble, n_hazard, n_busy;
  logic [1:0] n_state;
  logic [1:0] n_stall_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .STALL_CNT_WIDTH(8), .DRAIN_CYCLES(DRAIN)) u_dut (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req), .halt_req(halt_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_vld(id_rs1_vld), .id_rs2_vld(id_rs2_vld),
    .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
    .ex_wreg_en(ex_wreg_en), .mem_wreg_en(mem_wreg_en), .wb_wreg_en(wb_wreg_en),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .id_ex_bubble(id_ex_bubble), .hazard(hazard), .busy(busy),
    .state(dut_state), .stall_count(stall_count)
  );

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .STALL_CNT_WIDTH(2), .DRAIN_CYCLES(DRAIN)) u_dut_w2 (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req), .halt_req(halt_req),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_vld(id_rs1_vld), .id_rs2_vld(id_rs2_vld),
    .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
    .ex_wreg_en(ex_wreg_en), .mem_wreg_en(mem_wreg_en), .wb_wreg_en(wb_wreg_en),
    .pc_en(n_pc_en), .if_id_en(n_if_id_en), .id_ex_en(n_id_ex_en), .ex_mem_en(n_ex_mem_en),
    .mem_wb_en(n_mem_wb_en), .id_ex_bubble(n_bubble), .hazard(n_hazard), .busy(n_busy),
    .state(n_state), .stall_count(n_stall_count)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes: 0 idle, 1 run, 2 step, 3 drain. drain_left counts drain cycles still to go.
  int m_mode = 0;
  int m_drain_left = 0;
  int m_stalls = 0;

  function automatic bit model_hazard();
    logic [AW-1:0] src [2];
    bit            src_vld [2];
    logic [AW-1:0] dst [3];
    bit            dst_en [3];
    bit            hz = 1'b0;
    src[0] = id_rs1;  src_vld[0] = id_rs1_vld;
    src[1] = id_rs2;  src_vld[1] = id_rs2_vld;
    dst[0] = ex_wreg;  dst_en[0] = ex_wreg_en;
    dst[1] = mem_wreg; dst_en[1] = mem_wreg_en;
    dst[2] = wb_wreg;  dst_en[2] = wb_wreg_en;
    for (int s = 0; s < 2; s++) begin
      for (int d = 0; d < 3; d++) begin
        if (src_vld[s] && dst_en[d] && src[s] == dst[d]) begin
`ifdef PIPE_HAZARD_ZERO_REG_EN
          if (src[s] != '0) hz = 1'b1;
`else
          hz = 1'b1;
`endif
        end
      end
    end
    return hz;
  endfunction

  // Expected {pc, if_id, id_ex, ex_mem, mem_wb, bubble, hazard, busy}.
  function automatic logic [7:0] model_outs();
    bit hz = model_hazard();
    bit issuing = (m_mode == 1) || (m_mode == 2);
    bit frozen = (m_mode == 3) || (issuing && hz);
    bit moving = issuing || (m_mode == 3);
    return {moving && !frozen, moving && !frozen, moving, moving, moving,
            frozen, hz, m_mode != 0};
  endfunction

  function automatic logic [31:0] sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Model advance on each clock edge; mirrors the async reset.
  always @(posedge clk or posedge reset) begin
    bit hz;
    if (reset) begin
      m_mode = 0;
      m_drain_left = 0;
      m_stalls = 0;
    end else begin
      hz = model_hazard();
      if ((m_mode == 1 || m_mode == 2) && hz) m_stalls++;
      if (m_mode == 0) begin
        if (step_req) m_mode = 2;
        else if (run) m_mode = 1;
      end else if (m_mode == 1) begin
        if (halt_req || !run) begin
          m_mode = 3;
          m_drain_left = DRAIN;
        end
      end else if (m_mode == 2) begin
        m_mode = 0;
      end else begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] exp_state;
    exp_state = m_mode[1:0];
    check("outs", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, id_ex_bubble, hazard, busy},
          model_outs());
    check("state", dut_state, exp_state);
    check("stall_count", stall_count, sat(m_stalls, 255));
    check("outs_w2", {n_pc_en, n_if_id_en, n_id_ex_en, n_ex_mem_en, n_mem_wb_en, n_bubble,
                      n_hazard, n_busy}, model_outs());
    check("state_w2", n_state, exp_state);
    check("stall_count_w2", n_stall_count, sat(m_stalls, 3));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_regs();
    id_rs1 = '0; id_rs2 = '0; id_rs1_vld = 1'b0; id_rs2_vld = 1'b0;
    ex_wreg = '0; mem_wreg = '0; wb_wreg = '0;
    ex_wreg_en = 1'b0; mem_wreg_en = 1'b0; wb_wreg_en = 1'b0;
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_mem_wb_en", mem_wb_en, 1'b0);
    check("rst_state", dut_state, 2'd0);
    check("rst_stall", stall_count, 8'd0);
    check("rst_busy", busy, 1'b0);

    tick();
    reset = 1'b0;
    run = 1'b1;
    @(negedge clk);
    check("idle_before_run", dut_state, 2'd0);

    // RUN; source r2 hits EX, then MEM, then WB.
    tick();
    id_rs1 = 3'd2; id_rs1_vld = 1'b1;
    ex_wreg = 3'd2; ex_wreg_en = 1'b1;
    @(negedge clk);
    check("ex_hz_state", dut_state, 2'd1);
    check("ex_hz_pc_en", pc_en, 1'b0);
    check("ex_hz_bubble", id_ex_bubble, 1'b1);
    check("ex_hz_id_ex_en", id_ex_en, 1'b1);
    tick();
    ex_wreg_en = 1'b0; mem_wreg = 3'd2; mem_wreg_en = 1'b1;
    @(negedge clk);
    check("mem_hz_pc_en", pc_en, 1'b0);
    check("mem_hz_bubble", id_ex_bubble, 1'b1);
    tick();
    mem_wreg_en = 1'b0; wb_wreg = 3'd2; wb_wreg_en = 1'b1;
    @(negedge clk);
    check("wb_hz_pc_en", pc_en, 1'b0);
    check("wb_hz_hazard", hazard, 1'b1);
    tick();
    wb_wreg_en = 1'b0;
    @(negedge clk);
    check("clear_hazard", hazard, 1'b0);
    check("clear_pc_en", pc_en, 1'b1);
    check("stall_after_3", stall_count, 8'd3);
    check("stall_w2_after_3", n_stall_count, 2'd3);

    // Two more stall cycles: wide counter reaches 5, narrow one stays saturated.
    ex_wreg_en = 1'b1;
    tick();
    tick();
    ex_wreg_en = 1'b0;
    @(negedge clk);
    check("stall_after_5", stall_count, 8'd5);
    check("stall_w2_saturated", n_stall_count, 2'd3);

    // Halt with run held: three drain cycles, one idle cycle, then RUN again.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge clk);
      check("drain_state", dut_state, 2'd3);
      check("drain_pc_en", pc_en, 1'b0);
      check("drain_bubble", id_ex_bubble, 1'b1);
      check("drain_ex_mem_en", ex_mem_en, 1'b1);
      tick();
    end
    @(negedge clk);
    check("post_drain_idle", dut_state, 2'd0);
    check("post_drain_pc_en", pc_en, 1'b0);
    tick();
    @(negedge clk);
    check("rerun_state", dut_state, 2'd1);

    // Drop run, let it drain to IDLE, then single-step.
    run = 1'b0;
    repeat (DRAIN + 2) tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    @(negedge clk);
    check("step_state", dut_state, 2'd2);
    check("step_enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 5'b11111);
    tick();
    @(negedge clk);
    check("step_back_idle", dut_state, 2'd0);

    // Step into a hazard: one bubble, nothing fetched.
    id_rs1 = 3'd5; id_rs1_vld = 1'b1; ex_wreg = 3'd5; ex_wreg_en = 1'b1;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    @(negedge clk);
    check("step_hz_pc_en", pc_en, 1'b0);
    check("step_hz_bubble", id_ex_bubble, 1'b1);
    tick();
    clear_regs();
    @(negedge clk);
    check("step_hz_idle", dut_state, 2'd0);

    // Register 0 as source and WB destination.
    id_rs2 = 3'd0; id_rs2_vld = 1'b1; wb_wreg = 3'd0; wb_wreg_en = 1'b1;
    #1;
    check("zero_reg_hazard", hazard, ZERO_HZ_EXP);
    clear_regs();

    // Reset mid-RUN: enables drop in the same cycle.
    run = 1'b1;
    tick();
    tick();
    check("pre_reset_run", dut_state, 2'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_pc_en", pc_en, 1'b0);
    check("mid_rst_ex_mem_en", ex_mem_en, 1'b0);
    check("mid_rst_state", dut_state, 2'd0);
    check("mid_rst_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    run = 1'b0;

    // Randomized phase, checked by the compare process.
    for (int c = 0; c < 2000; c++) begin
      tick();
      if ($urandom_range(0, 15) == 0) run = ~run;
      step_req    = ($urandom_range(0, 9) == 0);
      halt_req    = ($urandom_range(0, 11) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      id_rs1      = AW'($urandom_range(0, 3));
      id_rs2      = AW'($urandom_range(0, 3));
      id_rs1_vld  = 1'($urandom_range(0, 1));
      id_rs2_vld  = 1'($urandom_range(0, 1));
      ex_wreg     = AW'($urandom_range(0, 3));
      mem_wreg    = AW'($urandom_range(0, 3));
      wb_wreg     = AW'($urandom_range(0, 3));
      ex_wreg_en  = 1'($urandom_range(0, 1));
      mem_wreg_en = 1'($urandom_range(0, 1));
      wb_wreg_en  = 1'($urandom_range(0, 1));
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
